preg_freelist: RTL and testbench
================================

PREG_FREELIST -- requirements
Module: preg_freelist

Interface
REQ-001 SHALL have parameter FETCH_WIDTH, default 4, giving the number of rename lanes.
REQ-002 SHALL have parameter COMMIT_WIDTH, default 4, giving the number of commit/walk lanes.
REQ-003 SHALL have parameter PREG_SIZE, default 128, giving the physical register count; PREG_WIDTH = clog2(PREG_SIZE); DEPTH = PREG_SIZE-32.
REQ-004 SHALL use the clock clk and the reset rst, which is asynchronous and active-high.
REQ-005 SHALL have port clk, input, 1 bit: clock.
REQ-006 SHALL have port rst, input, 1 bit: reset.
REQ-007 SHALL have port alloc_req, input, FETCH_WIDTH bits: the lane needs a new destination preg.
REQ-008 SHALL have port alloc_stall, input, 1 bit: downstream backpressure.
REQ-009 SHALL have port alloc_ready, output, 1 bit: enough free entries exist for all requesting lanes.
REQ-010 SHALL have port alloc_prd, output, FETCH_WIDTH x PREG_WIDTH bits: the allocated preg per lane.
REQ-011 SHALL have port commit_en / commit_we, input, COMMIT_WIDTH bits each: a committing instruction frees its old mapping.
REQ-012 SHALL have port commit_old_prd, input, COMMIT_WIDTH x PREG_WIDTH bits: the preg being freed.
REQ-013 SHALL have port walk / walk_en / walk_we, input, 1 / COMMIT_WIDTH / COMMIT_WIDTH bits: rollback of speculative allocations.
REQ-014 SHALL have port redirect, input, 1 bit: backend flush.
REQ-015 SHALL have port free_count, output, clog2(DEPTH+1) bits: the number of free entries.

Function
REQ-016 SHALL hold free preg indices in a circular array of DEPTH entries, with a head (allocate) pointer and a tail (free) pointer; each pointer SHALL carry a wrap flag and wrap modulo DEPTH.
REQ-017 SHALL compute alloc_fire = alloc_ready & ~alloc_stall & ~redirect & ~walk.
REQ-018 SHALL drive alloc_ready = (free_count >= popcount(alloc_req)); when alloc_req=0, alloc_ready SHALL be 1 and the head SHALL stay put.
REQ-019 SHALL drive alloc_prd[i] combinationally as array[head + number of requesting lanes below i]; the value is valid only where alloc_req[i]=1.
REQ-020 SHALL, on alloc_fire, advance the head by popcount(alloc_req) at the next clock edge; allocation is all-or-nothing, with no partial grants.
REQ-021 SHALL, when walk=0, write commit_old_prd[j] for each j with commit_en[j]&commit_we[j] to the tail in lane order, and advance the tail by that count.
REQ-022 SHALL ignore commit frees while walk=1.
REQ-023 SHALL, when walk=1, move the head back by popcount(walk_en&walk_we); the array contents SHALL be left unchanged.
REQ-024 SHALL make freed entries visible in free_count, and allocatable, from the cycle after the free; there is no same-cycle bypass.
REQ-025 SHALL apply an allocation and a free in the same cycle together: free_count_next = free_count - alloc_n + free_n.
REQ-026 SHALL treat a redirect cycle as blocking allocation only; frees in that cycle still apply.
REQ-027 SHALL register free_count, derived from the head/tail difference, and SHALL never exceed DEPTH.

Reset
REQ-028 SHALL, on rst, set array[i] = 32+i, head = 0, tail = 0 with opposite wrap flags (full), and free_count = DEPTH.
REQ-029 SHALL reset alloc_ready to 1 and make alloc_prd reflect the reset array; a reset mid-walk or mid-allocation discards all in-flight state.

Configuration
REQ-030 SHALL, when FREELIST_CHECK_EN is defined, add output err (1 bit, sticky, reset 0), set when:
- a free would exceed DEPTH;
- a walk would move the head past the tail;
- commit_en & walk are asserted in the same cycle.
REQ-031 SHALL, when FREELIST_CHECK_EN is undefined, omit the err port and its logic; all other behaviour is identical.

Structure
REQ-032 SHALL place ARCH_REG_NUM=32, the preg index type, the freelist pointer type (index plus wrap flag) and DEPTH in the shared backend package.
REQ-033 SHALL use one sub-module, freelist_compact, which gives each lane its offset (a prefix count of the request bits) and is reused for the alloc, free and walk lanes.

Verification
REQ-034 SHALL cover: after reset, alloc_req=4'b1111 with no stall -> alloc_prd = 32,33,34,35; next cycle free_count = 92.
REQ-035 SHALL cover: alloc_req=4'b1010 -> lane1 = 32, lane3 = 33; head advances by 2.
REQ-036 SHALL cover: drain to free_count = 2, then alloc_req=4'b0111 -> alloc_ready=0, head unchanged; free 2 pregs -> alloc_ready=1 in the following cycle.
REQ-037 SHALL cover: allocate 8, then walk with walk_en=walk_we=4'b1111 for 2 cycles -> free_count back to 96; the next allocation reissues 32..35.
REQ-038 SHALL cover: in one cycle, fire an allocation of 3 and a commit free of 2 -> free_count decreases by 1; wrap-around after DEPTH allocations and frees returns the freed indices in FIFO order.
REQ-039 SHALL cover, with FREELIST_CHECK_EN: freeing 1 preg while full -> err=1 and it stays set until rst.

Source files
------------

// File: rtl/preg_freelist_pkg.sv
// Shared backend definitions for the physical register free list:
// architectural register count, default physical register file size,
// the preg index type and the free-list pointer (index plus wrap flag).
package preg_freelist_pkg;

  localparam int ARCH_REG_NUM   = 32;
  localparam int PREG_SIZE_DEF  = 128;
  localparam int PREG_WIDTH_DEF = $clog2(PREG_SIZE_DEF);
  // Entries held by the free list: every preg not backing an architectural register.
  localparam int DEPTH          = PREG_SIZE_DEF - ARCH_REG_NUM;
  localparam int FL_IDX_WIDTH   = $clog2(DEPTH);
  localparam int FL_CNT_WIDTH   = $clog2(DEPTH + 1);

  typedef logic [PREG_WIDTH_DEF-1:0] preg_t;

  typedef struct packed {
    logic                    wrap;
    logic [FL_IDX_WIDTH-1:0] idx;
  } fl_ptr_t;

endpackage

// File: rtl/preg_freelist_if.sv
// Rename / commit / walk bundle between the backend and the preg free list.
// master = rename/commit/rollback side, slave = the free list itself.
interface preg_freelist_if
  import preg_freelist_pkg::*;
#(
  parameter int FETCH_WIDTH  = 4,
  parameter int COMMIT_WIDTH = 4,
  parameter int PREG_WIDTH   = PREG_WIDTH_DEF,
  parameter int CNT_WIDTH    = FL_CNT_WIDTH
);

  logic [FETCH_WIDTH-1:0]                  alloc_req;
  logic                                    alloc_stall;
  logic                                    alloc_ready;
  logic [FETCH_WIDTH-1:0][PREG_WIDTH-1:0]  alloc_prd;
  logic [COMMIT_WIDTH-1:0]                 commit_en;
  logic [COMMIT_WIDTH-1:0]                 commit_we;
  logic [COMMIT_WIDTH-1:0][PREG_WIDTH-1:0] commit_old_prd;
  logic                                    walk;
  logic [COMMIT_WIDTH-1:0]                 walk_en;
  logic [COMMIT_WIDTH-1:0]                 walk_we;
  logic                                    redirect;
  logic [CNT_WIDTH-1:0]                    free_count;

  modport master (
    output alloc_req, alloc_stall, commit_en, commit_we, commit_old_prd,
           walk, walk_en, walk_we, redirect,
    input  alloc_ready, alloc_prd, free_count
  );

  modport slave (
    input  alloc_req, alloc_stall, commit_en, commit_we, commit_old_prd,
           walk, walk_en, walk_we, redirect,
    output alloc_ready, alloc_prd, free_count
  );

endinterface

// File: rtl/preg_freelist_compact.sv
// freelist_compact: per-lane prefix count of the request bits, so each
// active lane knows its slot offset from the pointer, plus the total count.
module freelist_compact #(
  parameter int WIDTH = 4,
  parameter int OW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0]         req,
  output logic [WIDTH-1:0][OW-1:0] offset,
  output logic [OW-1:0]            total
);

  function automatic logic [OW-1:0] count_ones(input logic [WIDTH-1:0] v);
    logic [OW-1:0] c;
    c = '0;
    for (int k = 0; k < WIDTH; k++) c = c + OW'(v[k]);
    return c;
  endfunction

  // Each lane counts only the requests strictly below it (independent
  // adders rather than a ripple chain through the offset vector).
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
    localparam logic [WIDTH-1:0] BELOW = WIDTH'((64'd1 << gi) - 64'd1);
    assign offset[gi] = count_ones(req & BELOW);
  end

  assign total = count_ones(req);

endmodule

// File: rtl/preg_freelist.sv
// Physical register free list: circular array of free preg indices with a
// head (allocate) pointer and a tail (free) pointer, each carrying a wrap flag.
// Rename allocates all-or-nothing from the head, commit frees to the tail,
// walk rolls the head back. Optional FREELIST_CHECK_EN adds a sticky err output.
module preg_freelist
  import preg_freelist_pkg::*;
#(
  parameter int FETCH_WIDTH  = 4,
  parameter int COMMIT_WIDTH = 4,
  parameter int PREG_SIZE    = PREG_SIZE_DEF
) (
  input logic            clk,
  input logic            rst,
  preg_freelist_if.slave fl
`ifdef FREELIST_CHECK_EN
  ,
  output logic           err
`endif
);

  localparam int PREG_WIDTH = $clog2(PREG_SIZE);
  localparam int ENTRIES    = PREG_SIZE - ARCH_REG_NUM;
  localparam int IW         = $clog2(ENTRIES);
  localparam int CW         = $clog2(ENTRIES + 1);
  localparam int FOW        = $clog2(FETCH_WIDTH + 1);
  localparam int COW        = $clog2(COMMIT_WIDTH + 1);

  typedef struct packed {
    logic          wrap;
    logic [IW-1:0] idx;
  } ptr_t;

  function automatic logic [IW-1:0] idx_add(input logic [IW-1:0] idx, input int n);
    int s;
    s = int'(idx) + n;
    if (s >= ENTRIES) s = s - ENTRIES;
    return IW'(s);
  endfunction

  function automatic ptr_t ptr_add(input ptr_t p, input int n);
    ptr_t r;
    int   s;
    s      = int'(p.idx) + n;
    r.wrap = p.wrap;
    if (s >= ENTRIES) begin
      s      = s - ENTRIES;
      r.wrap = ~p.wrap;
    end
    r.idx = IW'(s);
    return r;
  endfunction

  function automatic ptr_t ptr_sub(input ptr_t p, input int n);
    ptr_t r;
    int   s;
    s      = int'(p.idx) - n;
    r.wrap = p.wrap;
    if (s < 0) begin
      s      = s + ENTRIES;
      r.wrap = ~p.wrap;
    end
    r.idx = IW'(s);
    return r;
  endfunction

  // Free entries lie in [head, tail); differing wrap flags mean tail has lapped.
  function automatic logic [CW-1:0] ptr_diff(input ptr_t t, input ptr_t h);
    int d;
    if (t.wrap == h.wrap) d = int'(t.idx) - int'(h.idx);
    else                  d = ENTRIES + int'(t.idx) - int'(h.idx);
    if (d > ENTRIES) d = ENTRIES;
    if (d < 0)       d = 0;
    return CW'(d);
  endfunction

  logic [PREG_WIDTH-1:0] fl_array [ENTRIES];
  ptr_t                  head_reg, head_next;
  ptr_t                  tail_reg, tail_next;
  logic [CW-1:0]         count_reg, count_next;

  logic [FETCH_WIDTH-1:0][FOW-1:0]  alloc_off;
  logic [FOW-1:0]                   alloc_n;
  logic [COMMIT_WIDTH-1:0]          free_req, walk_req;
  logic [COMMIT_WIDTH-1:0][COW-1:0] free_off, walk_off_unused;
  logic [COW-1:0]                   free_n, walk_n;
  logic                             alloc_fire;
  logic [FETCH_WIDTH-1:0][IW-1:0]   rd_idx;
  logic [COMMIT_WIDTH-1:0][IW-1:0]  wr_idx;

  assign free_req = fl.commit_en & fl.commit_we;
  assign walk_req = fl.walk_en & fl.walk_we;

  freelist_compact #(.WIDTH(FETCH_WIDTH), .OW(FOW)) u_alloc_compact (
    .req(fl.alloc_req), .offset(alloc_off), .total(alloc_n)
  );

  freelist_compact #(.WIDTH(COMMIT_WIDTH), .OW(COW)) u_free_compact (
    .req(free_req), .offset(free_off), .total(free_n)
  );

  // Walk only needs the total; per-lane offsets are not used.
  freelist_compact #(.WIDTH(COMMIT_WIDTH), .OW(COW)) u_walk_compact (
    .req(walk_req), .offset(walk_off_unused), .total(walk_n)
  );

  // Allocation read ports: lane i takes the slot skipping the requesters below it.
  for (genvar gi = 0; gi < FETCH_WIDTH; gi++) begin : g_rd
    assign rd_idx[gi]       = idx_add(head_reg.idx, int'(alloc_off[gi]));
    assign fl.alloc_prd[gi] = fl_array[rd_idx[gi]];
  end

  for (genvar gi = 0; gi < COMMIT_WIDTH; gi++) begin : g_wr
    assign wr_idx[gi] = idx_add(tail_reg.idx, int'(free_off[gi]));
  end

  assign fl.alloc_ready = (int'(count_reg) >= int'(alloc_n));
  assign fl.free_count  = count_reg;
  assign alloc_fire     = fl.alloc_ready & ~fl.alloc_stall & ~fl.redirect & ~fl.walk;

  // Next pointers: walk rewinds the head and suppresses frees; otherwise
  // allocate and free move independently in the same cycle.
  always_comb begin
    head_next = head_reg;
    tail_next = tail_reg;
    if (fl.walk) begin
      head_next = ptr_sub(head_reg, int'(walk_n));
    end else begin
      if (alloc_fire) head_next = ptr_add(head_reg, int'(alloc_n));
      tail_next = ptr_add(tail_reg, int'(free_n));
    end
    count_next = ptr_diff(tail_next, head_next);
  end

  // Pointer and registered free-count state; reset leaves the list full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_reg  <= '{wrap: 1'b0, idx: '0};
      tail_reg  <= '{wrap: 1'b1, idx: '0};
      count_reg <= CW'(ENTRIES);
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  // Free-list storage: reset holds every non-architectural preg in order;
  // commit frees are written at the tail in lane order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) fl_array[i] <= PREG_WIDTH'(ARCH_REG_NUM + i);
    end else begin
      for (int j = 0; j < COMMIT_WIDTH; j++) begin
        if (free_req[j] && !fl.walk) fl_array[wr_idx[j]] <= fl.commit_old_prd[j];
      end
    end
  end

`ifdef FREELIST_CHECK_EN
  logic err_reg;
  logic err_set;

  // Protocol violations: overfill, rewinding past the tail, commit during walk.
  always_comb begin
    err_set = 1'b0;
    if (fl.walk && (|fl.commit_en)) err_set = 1'b1;
    if (!fl.walk && (int'(count_reg) - (alloc_fire ? int'(alloc_n) : 0) + int'(free_n) > ENTRIES))
      err_set = 1'b1;
    if (fl.walk && (int'(count_reg) + int'(walk_n) > ENTRIES)) err_set = 1'b1;
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          err_reg <= 1'b0;
    else if (err_set) err_reg <= 1'b1;
  end

  assign err = err_reg;
`endif

endmodule

// File: tb/tb_preg_freelist.sv
// Testbench for preg_freelist: directed scenarios plus randomized traffic,
// checked by a scoreboard against a queue-based free-list model.
// Build with FREELIST_CHECK_EN defined to also exercise the sticky err output.
module tb_preg_freelist;
  import preg_freelist_pkg::*;

  localparam int FW   = 4;
  localparam int CWD  = 4;
  localparam int PW   = 7;
  localparam int NENT = 96;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  preg_freelist_if #(.FETCH_WIDTH(FW), .COMMIT_WIDTH(CWD), .PREG_WIDTH(PW), .CNT_WIDTH(7)) fl ();

`ifdef FREELIST_CHECK_EN
  logic err;
`endif

  preg_freelist #(.FETCH_WIDTH(FW), .COMMIT_WIDTH(CWD), .PREG_SIZE(128)) dut (
    .clk(clk),
    .rst(rst),
    .fl (fl)
`ifdef FREELIST_CHECK_EN
    ,
    .err(err)
`endif
  );

  typedef struct packed {
    int                   tag;
    logic [3:0]           req;
    logic                 ready;
    int                   cnt;
    logic [3:0][PW-1:0]   prd;
    logic                 chk_state;
    logic                 err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   freeq[$];   // free pregs, next to allocate at the front
  int   cons[$];    // allocated slots still holding their value, oldest first
  logic m_err;
  logic m_valid;
  int   checks = 0;
  int   passes = 0;
  int   tag    = 0;

  function automatic int pc4(input logic [3:0] v);
    int c;
    c = 0;
    for (int i = 0; i < 4; i++) c += int'(v[i]);
    return c;
  endfunction

  task automatic model_reset();
    freeq.delete();
    cons.delete();
    for (int i = 0; i < NENT; i++) freeq.push_back(32 + i);
    m_err   = 1'b0;
    m_valid = 1'b1;
  endtask

  function automatic exp_t make_exp(input logic [3:0] req);
    exp_t e;
    int   k;
    e.tag       = tag;
    e.req       = req;
    e.cnt       = freeq.size();
    e.ready     = (freeq.size() >= pc4(req));
    e.prd       = '0;
    e.chk_state = m_valid;
    e.err       = m_err;
    k = 0;
    for (int i = 0; i < 4; i++) begin
      if (req[i]) begin
        if (k < freeq.size()) e.prd[i] = PW'(freeq[k]);
        k++;
      end
    end
    return e;
  endfunction

  task automatic chk(input string nm, input int t, input int got, input int exp);
    checks++;
    if (got == exp) passes++;
    else $display("FAIL %s tag=%0d got=%0d expected=%0d", nm, t, got, exp);
  endtask

  // One clock of stimulus: drive, record expectation, advance the model.
  task automatic cycle(input logic [3:0] req, input logic stall, input logic redir,
                       input logic wlk, input logic [3:0] wen, input logic [3:0] wwe,
                       input logic [3:0] cen, input logic [3:0] cwe,
                       input logic [3:0][PW-1:0] cd);
    exp_t e;
    logic fire;
    int   n, wn, fn;
    fl.alloc_req      = req;
    fl.alloc_stall    = stall;
    fl.redirect       = redir;
    fl.walk           = wlk;
    fl.walk_en        = wen;
    fl.walk_we        = wwe;
    fl.commit_en      = cen;
    fl.commit_we      = cwe;
    fl.commit_old_prd = cd;
    e = make_exp(req);
    sb.push_back(e);
    if (m_valid) begin
      n    = pc4(req);
      fire = e.ready && !stall && !redir && !wlk;
      wn   = pc4(wen & wwe);
      fn   = pc4(cen & cwe);
`ifdef FREELIST_CHECK_EN
      if ((wlk && cen != 4'd0) || (!wlk && fn > cons.size() + (fire ? n : 0)) ||
          (wlk && wn > cons.size())) begin
        m_err   = 1'b1;
        m_valid = 1'b0;
      end
`endif
      if (m_valid) begin
        if (wlk) begin
          for (int k = 0; k < wn; k++) freeq.push_front(cons.pop_back());
        end else begin
          if (fire)
            for (int i = 0; i < 4; i++) if (req[i]) cons.push_back(freeq.pop_front());
          for (int j = 0; j < 4; j++) begin
            if (cen[j] && cwe[j]) begin
              void'(cons.pop_front());
              freeq.push_back(int'(cd[j]));
            end
          end
        end
      end
    end
    tag++;
    @(posedge clk);
    #1;
  endtask

  task automatic al(input logic [3:0] req);
    cycle(req, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, '0);
  endtask

  task automatic wk(input logic [3:0] wmask);
    cycle(4'd0, 1'b0, 1'b0, 1'b1, wmask, wmask, 4'd0, 4'd0, '0);
  endtask

  // Asynchronous reset asserted mid-cycle with a walk and allocation in flight.
  task automatic do_reset();
    fl.alloc_req   = 4'hF;
    fl.alloc_stall = 1'b0;
    fl.redirect    = 1'b0;
    fl.walk        = 1'b1;
    fl.walk_en     = 4'hF;
    fl.walk_we     = 4'hF;
    fl.commit_en   = 4'h0;
    fl.commit_we   = 4'h0;
    rst = 1'b1;
    model_reset();
    sb.push_back(make_exp(4'hF));
    tag++;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic random_cycle();
    logic [3:0]         req, wen, wwe, cen, cwe;
    logic [3:0][PW-1:0] cd;
    logic               stall, redir, wlk;
    req   = 4'($urandom_range(0, 15));
    stall = ($urandom_range(0, 4) == 0);
    redir = ($urandom_range(0, 19) == 0);
    wlk   = ($urandom_range(0, 9) == 0);
    wen   = 4'($urandom_range(0, 15));
    wwe   = 4'($urandom_range(0, 15));
    cen   = 4'($urandom_range(0, 15)) | 4'($urandom_range(0, 15));
    cwe   = 4'($urandom_range(0, 15));
    for (int j = 0; j < 4; j++) cd[j] = PW'($urandom_range(0, 127));
    if (!wlk) begin
      wen = 4'd0;
    end else begin
      if (pc4(wen & wwe) > cons.size()) wen = 4'd0;
`ifdef FREELIST_CHECK_EN
      cen = 4'd0;
`endif
    end
    if (pc4(cen & cwe) > cons.size()) cen = 4'd0;
    cycle(req, stall, redir, wlk, wen, wwe, cen, cwe, cd);
  endtask

  // Monitor: compare DUT outputs against the oldest expectation each cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      if (mon_e.chk_state) begin
        chk("free_count", mon_e.tag, int'(fl.free_count), mon_e.cnt);
        chk("alloc_ready", mon_e.tag, int'(fl.alloc_ready), int'(mon_e.ready));
        if (mon_e.ready) begin
          for (int i = 0; i < 4; i++)
            if (mon_e.req[i])
              chk($sformatf("alloc_prd[%0d]", i), mon_e.tag, int'(fl.alloc_prd[i]), int'(mon_e.prd[i]));
        end
      end
`ifdef FREELIST_CHECK_EN
      chk("err", mon_e.tag, int'(err), int'(mon_e.err));
`endif
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog tag=%0d got=timeout expected=finish", tag);
    $fatal(1, "watchdog expired");
  end

  initial begin
    fl.alloc_req      = 4'd0;
    fl.alloc_stall    = 1'b0;
    fl.redirect       = 1'b0;
    fl.walk           = 1'b0;
    fl.walk_en        = 4'd0;
    fl.walk_we        = 4'd0;
    fl.commit_en      = 4'd0;
    fl.commit_we      = 4'd0;
    fl.commit_old_prd = '0;
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;

    // Full-width allocation from reset: 32..35, then 92 free.
    do_reset();
    al(4'hF);
    al(4'h0);

    // Sparse lanes: lane1=32, lane3=33, head moves by 2.
    do_reset();
    al(4'b1010);
    al(4'b0001);
    al(4'h0);

    // Drain to 2 free, oversized request refused, frees visible next cycle.
    do_reset();
    repeat (23) al(4'hF);
    al(4'b1100);
    al(4'b0111);
    cycle(4'b0111, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'b0011, 4'b0011, {7'd0, 7'd0, 7'd6, 7'd5});
    al(4'b0111);
    al(4'h0);

    // Allocate 8 then walk back 8: count restored, 32..35 reissued.
    do_reset();
    al(4'hF);
    al(4'hF);
    wk(4'hF);
    wk(4'hF);
    al(4'hF);
    al(4'h0);

    // Allocate 3 and free 2 together, then redirect and stall cycles with frees.
    do_reset();
    al(4'hF);
    cycle(4'b0111, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'b0011, 4'b0011, {7'd0, 7'd0, 7'd41, 7'd40});
    cycle(4'hF, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'b0001, 4'b0001, {7'd0, 7'd0, 7'd0, 7'd42});
    cycle(4'hF, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'b1000, 4'b1000, {7'd43, 7'd0, 7'd0, 7'd0});
    al(4'h0);

`ifndef FREELIST_CHECK_EN
    // Commit frees presented during a walk are ignored.
    do_reset();
    al(4'hF);
    cycle(4'd0, 1'b0, 1'b0, 1'b1, 4'b0001, 4'b0001, 4'b0011, 4'b0011, {7'd0, 7'd0, 7'd9, 7'd8});
    al(4'h0);
`endif

    // Randomized traffic; many laps of the ring check FIFO order of frees.
    do_reset();
    repeat (1500) random_cycle();

    // Reset in the middle of traffic.
    do_reset();
    al(4'hF);
    al(4'h0);

`ifdef FREELIST_CHECK_EN
    // Freeing into a full list raises err, which holds until reset.
    do_reset();
    cycle(4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'b0001, 4'b0001, {7'd0, 7'd0, 7'd0, 7'd50});
    repeat (3) al(4'h0);
    do_reset();
    al(4'h0);
`endif

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      checks++;
      $display("FAIL scoreboard_drain tag=%0d got=%0d expected=0", tag, sb.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
